alu_exec_sequencer: RTL and testbench
=====================================

// Module: alu_exec_sequencer
// PURPOSE
//  Issue/sequencing controller for the EX-stage combinational ALU. Accepts one op per
//  valid/ready handshake, holds ALU operands stable in registers, waits MUL_CYCLES or
//  DIV_CYCLES for multi-cycle MUL/DIV, and returns a registered result.
//  Owns the architectural 3-bit flag register and resolves BRFL branches against it.
// PARAMETERS
//  MUL_CYCLES  4  ALU settle cycles for TYPE_R func 6'b000010 (MUL), >=1
//  DIV_CYCLES  8  ALU settle cycles for TYPE_R func 6'b000001 (DIV), >=1
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   reset, synchronous, active-low
//  flush          in   1   synchronous abort of in-flight op
//  issue_valid    in   1   op request
//  issue_ready    out  1   = (state==IDLE); accepts when valid&ready&!flush
//  issue_ctrl     in   3   ALU opcode: 000 ADDI, 001 SUBI, 010 TYPE_R, 011 ANDI, 100 ORI, 101 BRFL, 110 CMP
//  issue_func     in   6   TYPE_R function field
//  issue_a        in   32  operand A
//  issue_b        in   32  operand B / immediate; BRFL condition in [2:0]
//  alu_data_a     out  32  registered operand A to ALU
//  alu_data_b     out  32  registered operand B to ALU
//  alu_control    out  3   registered opcode to ALU
//  alu_func       out  6   registered func to ALU
//  alu_result     in   32  ALU result
//  alu_flag       in   3   ALU flag: 000 none, 001 equal, 010 exception, 011 ovf, 100 udf, 101 above
//  done_valid     out  1   one-cycle completion pulse
//  done_result    out  32  result, valid while done_valid
//  done_flag      out  3   flag for this op, valid while done_valid
//  done_branch    out  1   BRFL taken, valid while done_valid
//  flag_q         out  3   architectural flag register
// BEHAVIOUR
//  - Reset (reset==0 at edge): state IDLE; alu_* outputs, done_*, flag_q, counter = 0.
//  - States: IDLE, EXEC, WAIT. IDLE: accept -> latch issue_* into alu_* regs.
//    Single-cycle op -> EXEC. MUL, or DIV with issue_b!=0 -> WAIT, cnt=N-1.
//    DIV with issue_b==0 -> EXEC, div-by-zero marked.
//  - EXEC: at next edge capture, assert done_valid, return to IDLE.
//  - WAIT: cnt decrements each edge; capture at edge where cnt==0, then IDLE.
//  - Latency: accept at edge k -> done_valid high in cycle after edge k+1
//    (single-cycle or DIV/0) or edge k+N (N=MUL_CYCLES/DIV_CYCLES).
//    No back-to-back accept; next accept at earliest on done edge+1.
//  - Capture: done_result=alu_result, done_flag=alu_flag. DIV/0: result 0, flag 010.
//  - flag_q updated at capture for ADDI, SUBI, CMP, TYPE_R ADD/SUB/MUL/DIV (incl. DIV/0)
//    -> done_flag. AND/OR/NOT/ANDI/ORI, BRFL, unknown func: flag_q held,
//    done_flag = flag_q.
//  - CMP: done_result = 0; flag from alu_flag (a==b 001, a>b 101, else 000).
//  - BRFL: done_branch = (flag_q == alu_data_b[2:0]); done_result = 0;
//    done_branch = 0 for all other ops.
//  - Opcode 111 or unknown func: completes as single-cycle; result = alu_result.
//  - alu_* operand regs hold last op after completion; change only on accept.
//  - flush: any state -> IDLE next edge, no done_valid, flag_q unchanged.
//    flush with issue_valid in IDLE: no accept. flush on capture edge: flush wins.
//  - Reset mid-op overrides flush/capture; no done_valid follows.
// TESTING
//  - ADDI a=5 b=7: accept k -> done_valid cycle after k+1, result 12,
//    done_flag 000, flag_q 000.
//  - TYPE_R MUL 6*7, MUL_CYCLES=4: issue_ready low 4 cycles, done at k+4,
//    result 42; second issue held until ready.
//  - TYPE_R DIV a=9 b=0: done after k+1, result 0, done_flag 010, flag_q 010;
//    then ANDI 0xF0&0x3C -> result 0x30, flag_q stays 010.
//  - CMP 9,9 -> flag_q 001; BRFL b=1 -> branch 1; BRFL b=5 -> branch 0;
//    flag_q stays 001.
//  - DIV 100/7, DIV_CYCLES=8, flush at k+3: no done_valid, ready at k+4,
//    flag_q unchanged.
//  - reset low at k+2 of a MUL: all outputs 0 after that edge, no done_valid,
//    ready once reset high.

Source files
------------

// File: rtl/alu_exec_sequencer_if.sv
// Issue / ALU / completion bundle between the EX-stage sequencer and its neighbours.
// slave = sequencer side, master = issuing pipeline plus the combinational ALU.
interface alu_exec_sequencer_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_ctrl;
  logic [5:0]  issue_func;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [31:0] alu_data_a;
  logic [31:0] alu_data_b;
  logic [2:0]  alu_control;
  logic [5:0]  alu_func;
  logic [31:0] alu_result;
  logic [2:0]  alu_flag;
  logic        done_valid;
  logic [31:0] done_result;
  logic [2:0]  done_flag;
  logic        done_branch;
  logic [2:0]  flag_q;

  modport slave (
    input  issue_valid, issue_ctrl, issue_func, issue_a, issue_b, alu_result, alu_flag,
    output issue_ready, alu_data_a, alu_data_b, alu_control, alu_func,
           done_valid, done_result, done_flag, done_branch, flag_q
  );
  modport master (
    output issue_valid, issue_ctrl, issue_func, issue_a, issue_b, alu_result, alu_flag,
    input  issue_ready, alu_data_a, alu_data_b, alu_control, alu_func,
           done_valid, done_result, done_flag, done_branch, flag_q
  );
endinterface

// File: rtl/alu_exec_sequencer.sv
// EX-stage issue/sequencing controller: holds ALU operands, waits out MUL/DIV settle
// time, registers the result and owns the architectural flag register.
module alu_exec_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  alu_exec_sequencer_if.slave   bus
);
  localparam logic [2:0] OP_ADDI = 3'b000, OP_SUBI = 3'b001, OP_TYPER = 3'b010,
                         OP_BRFL = 3'b101, OP_CMP  = 3'b110;
  localparam logic [5:0] FN_DIV = 6'b000001, FN_MUL = 6'b000010,
                         FN_ADD = 6'b100000, FN_SUB = 6'b100010;
  localparam int CMAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     alu_a_q, alu_b_q;
  logic [2:0]      alu_ctrl_q;
  logic [5:0]      alu_func_q;
  logic            done_valid_q, done_branch_q;
  logic [31:0]     done_result_q;
  logic [2:0]      done_flag_q, arch_flag_q;

  logic            accept, capture, is_mul_i, is_div_i;
  logic            div0, upd_flag;
  logic [31:0]     res_w;
  logic [2:0]      new_flag;

  assign is_mul_i = (bus.issue_ctrl == OP_TYPER) && (bus.issue_func == FN_MUL);
  assign is_div_i = (bus.issue_ctrl == OP_TYPER) && (bus.issue_func == FN_DIV);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; flush aborts from any state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          if (is_mul_i) begin
            state_d = WAIT;
            cnt_d   = CW'(MUL_CYCLES - 1);
          end else if (is_div_i && (bus.issue_b != '0)) begin
            state_d = WAIT;
            cnt_d   = CW'(DIV_CYCLES - 1);
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: state_d = IDLE;
        WAIT: begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: handshake and capture strobe
  always_comb begin
    bus.issue_ready = (state_q == IDLE);
    accept          = bus.issue_valid && (state_q == IDLE) && !flush;
    capture         = !flush && ((state_q == EXEC) || ((state_q == WAIT) && (cnt_q == '0)));
  end

  // Result/flag shaping is decoded from the held operands, so no side state is needed
  assign div0     = (alu_ctrl_q == OP_TYPER) && (alu_func_q == FN_DIV) && (alu_b_q == '0);
  assign upd_flag = (alu_ctrl_q == OP_ADDI) || (alu_ctrl_q == OP_SUBI) || (alu_ctrl_q == OP_CMP) ||
                    ((alu_ctrl_q == OP_TYPER) && ((alu_func_q == FN_ADD) || (alu_func_q == FN_SUB) ||
                                                  (alu_func_q == FN_MUL) || (alu_func_q == FN_DIV)));
  assign new_flag = div0 ? 3'b010 : bus.alu_flag;
  assign res_w    = (div0 || (alu_ctrl_q == OP_CMP) || (alu_ctrl_q == OP_BRFL)) ? 32'h0 : bus.alu_result;

  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctrl_q    <= '0;
      alu_func_q    <= '0;
      done_valid_q  <= 1'b0;
      done_result_q <= '0;
      done_flag_q   <= '0;
      done_branch_q <= 1'b0;
      arch_flag_q   <= '0;
    end else begin
      done_valid_q <= capture;
      if (accept) begin
        alu_a_q    <= bus.issue_a;
        alu_b_q    <= bus.issue_b;
        alu_ctrl_q <= bus.issue_ctrl;
        alu_func_q <= bus.issue_func;
      end
      if (capture) begin
        done_result_q <= res_w;
        done_flag_q   <= upd_flag ? new_flag : arch_flag_q;
        done_branch_q <= (alu_ctrl_q == OP_BRFL) && (arch_flag_q == alu_b_q[2:0]);
        if (upd_flag) arch_flag_q <= new_flag;
      end
    end
  end

  assign bus.alu_data_a  = alu_a_q;
  assign bus.alu_data_b  = alu_b_q;
  assign bus.alu_control = alu_ctrl_q;
  assign bus.alu_func    = alu_func_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.done_result = done_result_q;
  assign bus.done_flag   = done_flag_q;
  assign bus.done_branch = done_branch_q;
  assign bus.flag_q      = arch_flag_q;
endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with a small behavioural ALU on the operand bus.
module tb_alu_exec_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat, nrdy, dv;

  alu_exec_sequencer_if bus();

  alu_exec_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; CMP/BRFL return a nonzero result so forcing to 0 is visible
  logic [31:0] sum_w;
  assign sum_w = bus.alu_data_a + bus.alu_data_b;
  always_comb begin
    bus.alu_result = 32'h0;
    bus.alu_flag   = 3'b000;
    case (bus.alu_control)
      3'b000: bus.alu_result = sum_w;
      3'b001: bus.alu_result = bus.alu_data_a - bus.alu_data_b;
      3'b010: begin
        case (bus.alu_func)
          6'b000010: bus.alu_result = bus.alu_data_a * bus.alu_data_b;
          6'b000001: begin
            if (bus.alu_data_b == 32'h0) bus.alu_flag = 3'b010;
            else bus.alu_result = bus.alu_data_a / bus.alu_data_b;
          end
          6'b100000: begin
            bus.alu_result = sum_w;
            if (bus.alu_data_a[31] == bus.alu_data_b[31] && sum_w[31] != bus.alu_data_a[31])
              bus.alu_flag = 3'b011;
          end
          default: bus.alu_result = bus.alu_data_a ^ bus.alu_data_b;
        endcase
      end
      3'b011: bus.alu_result = bus.alu_data_a & bus.alu_data_b;
      3'b100: bus.alu_result = bus.alu_data_a | bus.alu_data_b;
      3'b101: bus.alu_result = sum_w;
      3'b110: begin
        bus.alu_result = sum_w;
        if (bus.alu_data_a == bus.alu_data_b)     bus.alu_flag = 3'b001;
        else if (bus.alu_data_a > bus.alu_data_b) bus.alu_flag = 3'b101;
      end
      default: bus.alu_result = bus.alu_data_a ^ bus.alu_data_b;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents an op, waits (bounded) for ready, returns just after the accepting edge
  task automatic issue(input logic [2:0] c, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    bus.issue_valid = 1'b1;
    bus.issue_ctrl  = c;
    bus.issue_func  = f;
    bus.issue_a     = a;
    bus.issue_b     = b;
    while (!bus.issue_ready && t < 40) begin
      tick();
      t++;
    end
    chk("issue_ready_timeout", 32'(t < 40), 32'd1);
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic wait_done(output int l, output int nr);
    l  = 0;
    nr = 0;
    do begin
      if (!bus.issue_ready) nr++;
      tick();
      l++;
    end while (!bus.done_valid && l < 40);
  endtask

  initial begin
    bus.issue_valid = 1'b0;
    bus.issue_ctrl  = 3'b000;
    bus.issue_func  = 6'b000000;
    bus.issue_a     = 32'h0;
    bus.issue_b     = 32'h0;

    tick(); tick();
    chk("rst_ready",   32'(bus.issue_ready), 32'd1);
    chk("rst_alu_a",   bus.alu_data_a, 32'h0);
    chk("rst_alu_ctl", 32'(bus.alu_control), 32'h0);
    chk("rst_dvalid",  32'(bus.done_valid), 32'h0);
    chk("rst_dres",    bus.done_result, 32'h0);
    chk("rst_flag",    32'(bus.flag_q), 32'h0);
    reset = 1'b1;
    tick();

    // ADDI 5+7
    issue(3'b000, 6'h0, 32'd5, 32'd7);
    wait_done(lat, nrdy);
    chk("addi_lat",    32'(lat), 32'd1);
    chk("addi_res",    bus.done_result, 32'd12);
    chk("addi_dflag",  32'(bus.done_flag), 32'h0);
    chk("addi_flag",   32'(bus.flag_q), 32'h0);
    chk("addi_branch", 32'(bus.done_branch), 32'h0);
    tick();
    chk("addi_pulse",  32'(bus.done_valid), 32'h0);

    // MUL 6*7 with an ADDI 1+2 held waiting behind it
    issue(3'b010, 6'b000010, 32'd6, 32'd7);
    bus.issue_valid = 1'b1;
    bus.issue_ctrl  = 3'b000;
    bus.issue_func  = 6'h0;
    bus.issue_a     = 32'd1;
    bus.issue_b     = 32'd2;
    wait_done(lat, nrdy);
    chk("mul_lat",     32'(lat), 32'd4);
    chk("mul_nrdy",    32'(nrdy), 32'd4);
    chk("mul_res",     bus.done_result, 32'd42);
    chk("mul_opnd",    bus.alu_data_a, 32'd6);
    tick();
    chk("q_accepted",  32'(bus.issue_ready), 32'd0);
    bus.issue_valid = 1'b0;
    tick();
    chk("q_dvalid",    32'(bus.done_valid), 32'd1);
    chk("q_res",       bus.done_result, 32'd3);

    // DIV by zero, then ANDI leaves the flag alone
    issue(3'b010, 6'b000001, 32'd9, 32'd0);
    wait_done(lat, nrdy);
    chk("div0_lat",    32'(lat), 32'd1);
    chk("div0_res",    bus.done_result, 32'h0);
    chk("div0_dflag",  32'(bus.done_flag), 32'h2);
    chk("div0_flag",   32'(bus.flag_q), 32'h2);
    issue(3'b011, 6'h0, 32'hF0, 32'h3C);
    wait_done(lat, nrdy);
    chk("andi_res",    bus.done_result, 32'h30);
    chk("andi_dflag",  32'(bus.done_flag), 32'h2);
    chk("andi_flag",   32'(bus.flag_q), 32'h2);

    // CMP and BRFL
    issue(3'b110, 6'h0, 32'd9, 32'd9);
    wait_done(lat, nrdy);
    chk("cmp_res",     bus.done_result, 32'h0);
    chk("cmp_flag",    32'(bus.flag_q), 32'h1);
    issue(3'b101, 6'h0, 32'd3, 32'd1);
    wait_done(lat, nrdy);
    chk("brfl1_br",    32'(bus.done_branch), 32'd1);
    chk("brfl1_res",   bus.done_result, 32'h0);
    chk("brfl1_dflag", 32'(bus.done_flag), 32'h1);
    issue(3'b101, 6'h0, 32'd3, 32'd5);
    wait_done(lat, nrdy);
    chk("brfl5_br",    32'(bus.done_branch), 32'd0);
    chk("brfl5_flag",  32'(bus.flag_q), 32'h1);

    // DIV 100/7 flushed at k+3
    issue(3'b010, 6'b000001, 32'd100, 32'd7);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_ready",    32'(bus.issue_ready), 32'd1);
    dv = 0;
    repeat (8) begin
      if (bus.done_valid) dv++;
      tick();
    end
    chk("fl_nodone",   32'(dv), 32'd0);
    chk("fl_flag",     32'(bus.flag_q), 32'h1);

    // flush with issue_valid in IDLE must not accept
    bus.issue_valid = 1'b1;
    bus.issue_ctrl  = 3'b000;
    bus.issue_a     = 32'd1;
    bus.issue_b     = 32'd1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.issue_valid = 1'b0;
    chk("fi_ready",    32'(bus.issue_ready), 32'd1);
    tick();
    chk("fi_nodone",   32'(bus.done_valid), 32'd0);

    // flush on the capture edge of CMP 4,9 (would set flag 000)
    issue(3'b110, 6'h0, 32'd4, 32'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fc_nodone",   32'(bus.done_valid), 32'd0);
    chk("fc_flag",     32'(bus.flag_q), 32'h1);

    // opcode 111 completes single-cycle with raw ALU result
    issue(3'b111, 6'h0, 32'd5, 32'd3);
    wait_done(lat, nrdy);
    chk("op7_lat",     32'(lat), 32'd1);
    chk("op7_res",     bus.done_result, 32'd6);
    chk("op7_dflag",   32'(bus.done_flag), 32'h1);

    // TYPE_R ADD overflow updates flag; unknown func holds it
    issue(3'b010, 6'b100000, 32'h7FFF_FFFF, 32'd1);
    wait_done(lat, nrdy);
    chk("add_res",     bus.done_result, 32'h8000_0000);
    chk("add_flag",    32'(bus.flag_q), 32'h3);
    issue(3'b010, 6'b111111, 32'd3, 32'd5);
    wait_done(lat, nrdy);
    chk("unk_lat",     32'(lat), 32'd1);
    chk("unk_res",     bus.done_result, 32'd6);
    chk("unk_dflag",   32'(bus.done_flag), 32'h3);
    chk("unk_flag",    32'(bus.flag_q), 32'h3);

    // reset at k+2 of a MUL
    issue(3'b010, 6'b000010, 32'd6, 32'd7);
    tick();
    reset = 1'b0;
    tick();
    chk("rm_alu_a",    bus.alu_data_a, 32'h0);
    chk("rm_alu_b",    bus.alu_data_b, 32'h0);
    chk("rm_alu_func", 32'(bus.alu_func), 32'h0);
    chk("rm_dres",     bus.done_result, 32'h0);
    chk("rm_dflag",    32'(bus.done_flag), 32'h0);
    chk("rm_flag",     32'(bus.flag_q), 32'h0);
    reset = 1'b1;
    dv = 0;
    repeat (6) begin
      if (bus.done_valid) dv++;
      tick();
    end
    chk("rm_nodone",   32'(dv), 32'd0);
    chk("rm_ready",    32'(bus.issue_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
